// File: rtl/bomb_pkg.sv
// Purpose : shared types and constants for the bomb slot scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package bomb_pkg;

    localparam int TILE_SIZE        = 32;   // board tile pitch in pixels; bomb positions sit on this grid
    localparam int COORD_W          = 11;   // pixel coordinate width
    localparam int DEF_FUSE_FRAMES  = 120;
    localparam int DEF_BLAST_FRAMES = 30;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FUSE  = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_e;

endpackage

// File: rtl/bomb_slot_fsm.sv
// Purpose : one bomb slot; holds lifecycle state, frame timer and latched position.
// Latency : all outputs registered, valid the cycle after the causing event.
// Backpressure: none; alloc_i is only asserted by the scheduler when the slot is IDLE.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   sof_i                  frame tick
//   alloc_i                place a bomb into this slot (slot must be IDLE)
//   place_x_i, place_y_i   position latched on alloc_i
//   chain_hit_i            force FUSE -> BLAST (ignored in other states)
//   active_o, blast_o      slot is in FUSE / BLAST
//   explode_o              one-cycle pulse coincident with entry to BLAST
//   pos_x_o, pos_y_o       latched position (held after the slot goes IDLE)
module bomb_slot_fsm
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES  = DEF_FUSE_FRAMES,
    parameter int BLAST_FRAMES = DEF_BLAST_FRAMES,
    parameter int CNT_W        = 7
) (
    input  logic   clk,
    input  logic   resetN,
    input  logic   sof_i,
    input  logic   alloc_i,
    input  coord_t place_x_i,
    input  coord_t place_y_i,
    input  logic   chain_hit_i,
    output logic   active_o,
    output logic   blast_o,
    output logic   explode_o,
    output coord_t pos_x_o,
    output coord_t pos_y_o
);

    // Timers count down to zero and the transition happens on the tick that
    // sees zero, so a load of N-1 gives a phase of exactly N frame ticks.
    localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_FRAMES - 1);

    slot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    coord_t            x_q, x_d, y_q, y_d;
    logic              explode_q, explode_d;
    logic              active_q, blast_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= SLOT_IDLE;
            timer_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            explode_q <= 1'b0;
            active_q  <= 1'b0;
            blast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            x_q       <= x_d;
            y_q       <= y_d;
            explode_q <= explode_d;
            // Flags are decoded from next state so they leave a flop directly.
            active_q  <= (state_d == SLOT_FUSE);
            blast_q   <= (state_d == SLOT_BLAST);
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        x_d       = x_q;
        y_d       = y_q;
        explode_d = 1'b0;
        unique case (state_q)
            SLOT_IDLE: begin
                // A freshly placed bomb ignores a coincident frame tick.
                if (alloc_i) begin
                    state_d = SLOT_FUSE;
                    timer_d = FUSE_LOAD;
                    x_d     = place_x_i;
                    y_d     = place_y_i;
                end
            end
            SLOT_FUSE: begin
                // Chain hit takes priority over a simultaneous frame tick.
                if (chain_hit_i || (sof_i && timer_q == '0)) begin
                    state_d   = SLOT_BLAST;
                    timer_d   = BLAST_LOAD;
                    explode_d = 1'b1;
                end else if (sof_i) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SLOT_BLAST: begin
                if (sof_i) begin
                    if (timer_q == '0) begin
                        state_d = SLOT_IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = SLOT_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign active_o  = active_q;
    assign blast_o   = blast_q;
    assign explode_o = explode_q;
    assign pos_x_o   = x_q;
    assign pos_y_o   = y_q;

endmodule

// File: rtl/bomb_slot_scheduler.sv
// Purpose : allocates bomb slots on placement requests and runs per-slot fuse/blast timers.
// Latency : 1 cycle from placeReq to placeAck/placeReject; all outputs registered.
// Backpressure: none; a request that cannot be served is refused with placeReject.
//
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   startOfFrame              one-cycle frame tick
//   placeReq, placeX, placeY  placement request and top-left pixel position
//   placeAck, placeReject     one-cycle request outcome, mutually exclusive
//   chainHit                  per-slot: another blast covers this bomb
//   detonateReq               (BOMB_REMOTE_DETONATE_EN only) blast every fusing bomb
//   bombActive, blastActive   per-slot FUSE / BLAST flags
//   bombX, bombY              packed per-slot positions, slot i at [11i+10:11i]
//   explodeMask               per-slot pulse on entry to BLAST
// Optional feature macro: BOMB_REMOTE_DETONATE_EN adds the detonateReq input.
module bomb_slot_scheduler
    import bomb_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int FUSE_FRAMES  = DEF_FUSE_FRAMES,
    parameter int BLAST_FRAMES = DEF_BLAST_FRAMES,
    parameter int CNT_W        = 7
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         placeReq,
    input  logic [COORD_W-1:0]           placeX,
    input  logic [COORD_W-1:0]           placeY,
    output logic                         placeAck,
    output logic                         placeReject,
    input  logic [NUM_SLOTS-1:0]         chainHit,
`ifdef BOMB_REMOTE_DETONATE_EN
    input  logic                         detonateReq,
`endif
    output logic [NUM_SLOTS-1:0]         bombActive,
    output logic [NUM_SLOTS-1:0]         blastActive,
    output logic [NUM_SLOTS*COORD_W-1:0] bombX,
    output logic [NUM_SLOTS*COORD_W-1:0] bombY,
    output logic [NUM_SLOTS-1:0]         explodeMask
);

    coord_t               pos_x [NUM_SLOTS];
    coord_t               pos_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy;
    logic [NUM_SLOTS-1:0] dup_hit;
    logic [NUM_SLOTS-1:0] free_pick;
    logic [NUM_SLOTS-1:0] alloc;
    logic [NUM_SLOTS-1:0] chain_eff;
    logic                 have_free;
    logic                 accept;
    logic                 ack_q, reject_q;

    // A slot still in BLAST this cycle counts as busy even if it leaves
    // BLAST on this very edge, so it cannot serve a same-cycle request.
    always_comb begin
        busy      = bombActive | blastActive;
        dup_hit   = '0;
        free_pick = '0;
        have_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dup_hit[i] = busy[i] && (pos_x[i] == placeX) && (pos_y[i] == placeY);
            if (!busy[i] && !have_free) begin
                free_pick[i] = 1'b1;
                have_free    = 1'b1;
            end
        end
    end

    assign accept = placeReq && have_free && !(|dup_hit);
    assign alloc  = accept ? free_pick : '0;

`ifdef BOMB_REMOTE_DETONATE_EN
    // Remote detonation behaves like a chain hit on every slot; only FUSE slots react.
    assign chain_eff = chainHit | {NUM_SLOTS{detonateReq}};
`else
    assign chain_eff = chainHit;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ack_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            ack_q    <= accept;
            reject_q <= placeReq && !accept;
        end
    end

    assign placeAck    = ack_q;
    assign placeReject = reject_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bomb_slot_fsm #(
            .FUSE_FRAMES  (FUSE_FRAMES),
            .BLAST_FRAMES (BLAST_FRAMES),
            .CNT_W        (CNT_W)
        ) u_slot (
            .clk         (clk),
            .resetN      (resetN),
            .sof_i       (startOfFrame),
            .alloc_i     (alloc[g]),
            .place_x_i   (placeX),
            .place_y_i   (placeY),
            .chain_hit_i (chain_eff[g]),
            .active_o    (bombActive[g]),
            .blast_o     (blastActive[g]),
            .explode_o   (explodeMask[g]),
            .pos_x_o     (pos_x[g]),
            .pos_y_o     (pos_y[g])
        );

        assign bombX[g*COORD_W +: COORD_W] = pos_x[g];
        assign bombY[g*COORD_W +: COORD_W] = pos_y[g];
    end

endmodule

// File: tb/tb_bomb_slot_scheduler.sv
module tb_bomb_slot_scheduler;

    localparam int NS = 4;
    localparam int FF = 4;
    localparam int BF = 2;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic            placeReq;
    logic [10:0]     placeX;
    logic [10:0]     placeY;
    logic            placeAck;
    logic            placeReject;
    logic [NS-1:0]   chainHit;
    logic [NS-1:0]   bombActive;
    logic [NS-1:0]   blastActive;
    logic [NS*11-1:0] bombX;
    logic [NS*11-1:0] bombY;
    logic [NS-1:0]   explodeMask;
`ifdef BOMB_REMOTE_DETONATE_EN
    logic            detonateReq;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          ack;
        int          slot;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bomb_slot_scheduler #(
        .NUM_SLOTS    (NS),
        .FUSE_FRAMES  (FF),
        .BLAST_FRAMES (BF),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .placeReq     (placeReq),
        .placeX       (placeX),
        .placeY       (placeY),
        .placeAck     (placeAck),
        .placeReject  (placeReject),
        .chainHit     (chainHit),
`ifdef BOMB_REMOTE_DETONATE_EN
        .detonateReq  (detonateReq),
`endif
        .bombActive   (bombActive),
        .blastActive  (blastActive),
        .bombX        (bombX),
        .bombY        (bombY),
        .explodeMask  (explodeMask)
    );

    // Scoreboard: every request pushes its expected outcome on the sampling
    // edge; the response must appear on the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (resetN === 1'b1) begin
            if (placeAck === 1'b1 || placeReject === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected ack=%0b reject=%0b required no response", placeAck, placeReject);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({placeAck, placeReject} !== {e.ack, ~e.ack}) begin
                        failures++;
                        $display("FAIL sb_outcome ack/rej=%b%b required %b%b (x=%0d y=%0d)",
                                 placeAck, placeReject, e.ack, ~e.ack, e.x, e.y);
                    end
                    if (e.ack) begin
                        checks++;
                        if (bombActive[e.slot] !== 1'b1 || bombX[e.slot*11 +: 11] !== e.x ||
                            bombY[e.slot*11 +: 11] !== e.y) begin
                            failures++;
                            $display("FAIL sb_slot slot=%0d active=%b x=%0d y=%0d required active=1 x=%0d y=%0d",
                                     e.slot, bombActive[e.slot], bombX[e.slot*11 +: 11],
                                     bombY[e.slot*11 +: 11], e.x, e.y);
                        end
                    end
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL sb_missing no ack/reject seen, required ack=%0b for x=%0d y=%0d", e.ack, e.x, e.y);
            end
        end
    end

    // All drive tasks start and end at a negedge.
    task automatic place(input logic [10:0] x, input logic [10:0] y,
                         input bit exp_ack, input int exp_slot, input bit sof);
        exp_t e;
        placeReq     = 1'b1;
        placeX       = x;
        placeY       = y;
        startOfFrame = sof;
        @(posedge clk);
        e.ack  = exp_ack;
        e.slot = exp_slot;
        e.x    = x;
        e.y    = y;
        sb.push_back(e);
        @(negedge clk);
        placeReq     = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        placeReq     = 1'b0;
        placeX       = '0;
        placeY       = '0;
        chainHit     = '0;
`ifdef BOMB_REMOTE_DETONATE_EN
        detonateReq  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        sb.delete();
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        placeReq     = 1'b0;
        placeX       = '0;
        placeY       = '0;
        chainHit     = '0;
`ifdef BOMB_REMOTE_DETONATE_EN
        detonateReq  = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if ({bombActive, blastActive, explodeMask} !== 12'h000) begin
            failures++;
            $display("FAIL reset_flags got %b/%b/%b required all 0", bombActive, blastActive, explodeMask);
        end
        checks++;
        if ({placeAck, placeReject} !== 2'b00 || bombX !== '0 || bombY !== '0) begin
            failures++;
            $display("FAIL reset_pos ack=%b rej=%b x=%h y=%h required 0", placeAck, placeReject, bombX, bombY);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fuse_lifecycle();
        do_reset();
        place(11'd64, 11'd96, 1'b1, 0, 1'b0);
        idle_cycle();
        checks++;
        if (placeAck !== 1'b0) begin
            failures++;
            $display("FAIL ack_width placeAck=%b required 0", placeAck);
        end
        for (int k = 1; k < FF; k++) begin
            frame();
            checks++;
            if (bombActive !== 4'b0001 || blastActive !== 4'b0000 || explodeMask !== 4'b0000) begin
                failures++;
                $display("FAIL fuse_hold tick=%0d bomb=%b blast=%b expl=%b required 0001/0000/0000",
                         k, bombActive, blastActive, explodeMask);
            end
        end
        frame();
        checks++;
        if (bombActive !== 4'b0000 || blastActive !== 4'b0001 || explodeMask !== 4'b0001) begin
            failures++;
            $display("FAIL fuse_expire bomb=%b blast=%b expl=%b required 0000/0001/0001",
                     bombActive, blastActive, explodeMask);
        end
        idle_cycle();
        checks++;
        if (explodeMask !== 4'b0000 || blastActive !== 4'b0001) begin
            failures++;
            $display("FAIL explode_width expl=%b blast=%b required 0000/0001", explodeMask, blastActive);
        end
        frame();
        checks++;
        if (blastActive !== 4'b0001) begin
            failures++;
            $display("FAIL blast_hold blast=%b required 0001", blastActive);
        end
        frame();
        checks++;
        if (blastActive !== 4'b0000 || bombActive !== 4'b0000 || bombX[10:0] !== 11'd64 || bombY[10:0] !== 11'd96) begin
            failures++;
            $display("FAIL blast_end bomb=%b blast=%b x=%0d y=%0d required 0000/0000 x=64 y=96",
                     bombActive, blastActive, bombX[10:0], bombY[10:0]);
        end
    endtask

    task automatic test_duplicate_and_full();
        do_reset();
        place(11'd64, 11'd96, 1'b1, 0, 1'b0);
        place(11'd64, 11'd96, 1'b0, 0, 1'b0);
        checks++;
        if (bombActive !== 4'b0001) begin
            failures++;
            $display("FAIL dup_no_alloc bomb=%b required 0001", bombActive);
        end
        place(11'd96,  11'd96, 1'b1, 1, 1'b0);
        place(11'd128, 11'd96, 1'b1, 2, 1'b0);
        place(11'd160, 11'd96, 1'b1, 3, 1'b0);
        place(11'd192, 11'd96, 1'b0, 0, 1'b0);
        checks++;
        if (bombActive !== 4'b1111) begin
            failures++;
            $display("FAIL full_state bomb=%b required 1111", bombActive);
        end
        repeat (FF) frame();
        checks++;
        if (explodeMask !== 4'b1111 || blastActive !== 4'b1111) begin
            failures++;
            $display("FAIL multi_explode expl=%b blast=%b required 1111/1111", explodeMask, blastActive);
        end
        repeat (BF) frame();
        place(11'd192, 11'd96, 1'b1, 0, 1'b0);
    endtask

    task automatic test_chain_hit();
        do_reset();
        place(11'd0,  11'd0, 1'b1, 0, 1'b0);
        place(11'd32, 11'd0, 1'b1, 1, 1'b0);
        place(11'd64, 11'd0, 1'b1, 2, 1'b0);
        chainHit = 4'b1100;   // bit 3 targets an IDLE slot
        idle_cycle();
        checks++;
        if (explodeMask !== 4'b0100 || blastActive !== 4'b0100 || bombActive !== 4'b0011) begin
            failures++;
            $display("FAIL chain_hit expl=%b blast=%b bomb=%b required 0100/0100/0011",
                     explodeMask, blastActive, bombActive);
        end
        idle_cycle();         // chainHit held while slot 2 is already in BLAST
        checks++;
        if (explodeMask !== 4'b0000 || blastActive !== 4'b0100 || bombActive !== 4'b0011) begin
            failures++;
            $display("FAIL chain_in_blast expl=%b blast=%b bomb=%b required 0000/0100/0011",
                     explodeMask, blastActive, bombActive);
        end
        chainHit     = 4'b0010;
        startOfFrame = 1'b1;
        idle_cycle();
        chainHit     = 4'b0000;
        startOfFrame = 1'b0;
        checks++;
        if (explodeMask !== 4'b0010 || blastActive !== 4'b0110 || bombActive !== 4'b0001) begin
            failures++;
            $display("FAIL chain_with_sof expl=%b blast=%b bomb=%b required 0010/0110/0001",
                     explodeMask, blastActive, bombActive);
        end
        frame();
        frame();
        checks++;
        if (blastActive !== 4'b0000 || bombActive !== 4'b0001) begin
            failures++;
            $display("FAIL chain_blast_end blast=%b bomb=%b required 0000/0001", blastActive, bombActive);
        end
        frame();              // fourth tick since slot 0 was placed
        checks++;
        if (explodeMask !== 4'b0001 || blastActive !== 4'b0001) begin
            failures++;
            $display("FAIL chain_slot0_expire expl=%b blast=%b required 0001/0001", explodeMask, blastActive);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        place(11'd64, 11'd96, 1'b1, 0, 1'b1);
        repeat (FF - 1) frame();
        checks++;
        if (bombActive !== 4'b0001 || blastActive !== 4'b0000) begin
            failures++;
            $display("FAIL place_on_sof bomb=%b blast=%b required 0001/0000", bombActive, blastActive);
        end
        frame();
        checks++;
        if (blastActive !== 4'b0001 || explodeMask !== 4'b0001) begin
            failures++;
            $display("FAIL place_on_sof_expire blast=%b expl=%b required 0001/0001", blastActive, explodeMask);
        end
        frame();              // blast timer now at its last tick
        place(11'd96,  11'd96, 1'b1, 1, 1'b0);
        place(11'd128, 11'd96, 1'b1, 2, 1'b0);
        place(11'd160, 11'd96, 1'b1, 3, 1'b0);
        place(11'd192, 11'd96, 1'b0, 0, 1'b1);
        checks++;
        if (blastActive !== 4'b0000 || bombActive !== 4'b1110) begin
            failures++;
            $display("FAIL leave_blast_reject blast=%b bomb=%b required 0000/1110", blastActive, bombActive);
        end
        place(11'd192, 11'd96, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_blast();
        do_reset();
        place(11'd64, 11'd96, 1'b1, 0, 1'b0);
        repeat (FF) frame();
        checks++;
        if (blastActive !== 4'b0001) begin
            failures++;
            $display("FAIL pre_reset_blast blast=%b required 0001", blastActive);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({bombActive, blastActive, explodeMask, placeAck, placeReject} !== 14'h0 ||
            bombX !== '0 || bombY !== '0) begin
            failures++;
            $display("FAIL async_reset bomb=%b blast=%b expl=%b x=%h y=%h required all 0",
                     bombActive, blastActive, explodeMask, bombX, bombY);
        end
        @(negedge clk);
        sb.delete();
        resetN = 1'b1;
        @(negedge clk);
        place(11'd64, 11'd96, 1'b1, 0, 1'b0);
    endtask

`ifdef BOMB_REMOTE_DETONATE_EN
    task automatic test_remote_detonate();
        do_reset();
        place(11'd0,  11'd32, 1'b1, 0, 1'b0);
        place(11'd32, 11'd32, 1'b1, 1, 1'b0);
        place(11'd64, 11'd32, 1'b1, 2, 1'b0);
        detonateReq = 1'b1;
        idle_cycle();
        detonateReq = 1'b0;
        checks++;
        if (explodeMask !== 4'b0111 || blastActive !== 4'b0111) begin
            failures++;
            $display("FAIL remote_detonate expl=%b blast=%b required 0111/0111", explodeMask, blastActive);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fuse_lifecycle();
        test_duplicate_and_full();
        test_chain_hit();
        test_simultaneous();
        test_reset_mid_blast();
`ifdef BOMB_REMOTE_DETONATE_EN
        test_remote_detonate();
`endif
        idle_cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
